// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave register-file back end.
package i2c_slave_pkg;

   typedef enum logic [0:0] {
      ST_PTR,
      ST_DATA
   } state_e;

   localparam logic [7:0] ZERO8             = 8'h00;
   localparam logic [6:0] DEF_SLAVE_ADDRESS = 7'h3C;
   localparam logic [7:0] DEF_CHIP_ID       = 8'hA5;

endpackage

// File: rtl/i2c_slave_regfile_edge.sv
// Rise detector for one level strobe from the byte engine.
module i2c_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   output logic rise
);

   logic cur_q;
   logic last_q;

   // Sample the strobe and keep the previous sample.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cur_q  <= 1'b0;
         last_q <= 1'b0;
      end else begin
         cur_q  <= sig;
         last_q <= cur_q;
      end
   end

   assign rise = cur_q & ~last_q;

endmodule

// File: rtl/i2c_slave_regfile.sv
// Register-file back end: pointer byte, auto-increment, read-only chip ID at index 0.
module i2c_slave_regfile
   import i2c_slave_pkg::*;
#(
   parameter logic [6:0]  SLAVE_ADDRESS = DEF_SLAVE_ADDRESS,
   parameter logic [7:0]  CHIP_ID       = DEF_CHIP_ID,
   parameter int unsigned REG_COUNT     = 8,
   parameter int unsigned REG_AW        = $clog2(REG_COUNT)
) (
   input  logic              clk,
   input  logic              reset,
   output logic [6:0]        address,
   input  logic [7:0]        datareceive,
   input  logic              received,
   output logic [7:0]        datasend,
   input  logic              sended,
   input  logic              stop,
   input  logic              host_we,
   input  logic [REG_AW-1:0] host_addr,
   input  logic [7:0]        host_wdata,
   output logic [7:0]        host_rdata,
   output logic              wr_strobe,
   output logic [REG_AW-1:0] wr_index,
   output logic              ptr_err
);

   state_e            state_q, state_d;
   logic [REG_AW-1:0] ptr_q, ptr_d, ptr_inc;
   logic              reload_q, reload_d;
   logic              err_q, err_d;
   logic [7:0]        data_q;
   logic [7:0]        datasend_q;
   logic              wr_strobe_q;
   logic [REG_AW-1:0] wr_index_q;
   logic              i2c_we;
   logic              rx_ev, tx_ev, stop_ev;
   logic [7:0]        regs_q [REG_COUNT];

   i2c_edge_detect u_rx_edge (.clk(clk), .reset(reset), .sig(received), .rise(rx_ev));
   i2c_edge_detect u_tx_edge (.clk(clk), .reset(reset), .sig(sended), .rise(tx_ev));
   i2c_edge_detect u_stop_edge (.clk(clk), .reset(reset), .sig(stop), .rise(stop_ev));

   assign ptr_inc = (ptr_q == REG_AW'(REG_COUNT - 1)) ? '0 : ptr_q + REG_AW'(1);

   // Next-state decode: stop beats rx, rx beats tx.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      reload_d = 1'b0;
      err_d    = err_q;
      i2c_we   = 1'b0;
      if (stop_ev) begin
         state_d = ST_PTR;
      end else if (rx_ev) begin
         unique case (state_q)
            ST_PTR: begin
               if (32'(data_q) < REG_COUNT) begin
                  ptr_d = data_q[REG_AW-1:0];
               end else begin
                  ptr_d = '0;
                  err_d = 1'b1;
               end
               state_d  = ST_DATA;
               reload_d = 1'b1;
            end
            ST_DATA: begin
               i2c_we = 1'b1;
               ptr_d  = ptr_inc;
            end
            default: state_d = ST_PTR;
         endcase
      end else if (tx_ev) begin
         ptr_d    = ptr_inc;
         reload_d = 1'b1;
      end
   end

   // Control state, captured byte, write strobe and transmit byte.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_PTR;
         ptr_q       <= '0;
         reload_q    <= 1'b0;
         err_q       <= 1'b0;
         data_q      <= ZERO8;
         datasend_q  <= ZERO8;
         wr_strobe_q <= 1'b0;
         wr_index_q  <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         reload_q    <= reload_d;
         err_q       <= err_d;
         // Captured alongside the strobe sample so the byte is used even if it drops.
         data_q      <= datareceive;
         wr_strobe_q <= i2c_we;
         if (i2c_we) begin
            wr_index_q <= ptr_q;
         end
         // Pointer is already updated when the reload flag is seen.
         if (reload_q) begin
            datasend_q <= regs_q[ptr_q];
         end
      end
   end

   // Register array; index 0 holds the chip ID and is never written.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs_q[i] <= (i == 0) ? CHIP_ID : ZERO8;
         end
      end else begin
         for (int i = 1; i < REG_COUNT; i++) begin
            if (i2c_we && ptr_q == REG_AW'(i)) begin
               regs_q[i] <= data_q;
            end else if (host_we && host_addr == REG_AW'(i)) begin
               regs_q[i] <= host_wdata;
            end
         end
      end
   end

   assign address    = SLAVE_ADDRESS;
   assign datasend   = datasend_q;
   assign wr_strobe  = wr_strobe_q;
   assign wr_index   = wr_index_q;
   assign ptr_err    = err_q;
   assign host_rdata = (32'(host_addr) < REG_COUNT) ? regs_q[host_addr] : ZERO8;

endmodule

// File: doc/i2c_slave_regfile.md
# i2c_slave_regfile

Byte-level register-file back end for the I2C slave datapath, the parametrised successor of the single-register chip-ID driver. It sits between the I2C slave byte engine (which supplies `received`/`sended` byte strobes and `datareceive`) and the system. It exposes `REG_COUNT` 8-bit registers with an auto-incrementing pointer, a read-only chip-ID register at index 0, and a host-side port for the local logic.

## Interface
- `SLAVE_ADDRESS`, 7'h3C: I2C device address driven on `address`.
- `CHIP_ID`, 8'hA5: constant value of register 0.
- `REG_COUNT`, 8: number of registers, 2..256.
- `REG_AW`, $clog2(REG_COUNT): pointer/index width.

Ports:
- `clk`  in  1  clock; all logic on posedge.
- `reset`  in  1  reset, synchronous, active-low.
- `address`  out  7  constant `SLAVE_ADDRESS`.
- `datareceive`  in  8  byte from the byte engine, valid while `received` is high.
- `received`  in  1  level; a rising edge marks one received byte.
- `datasend`  out  8  next byte for the engine to transmit.
- `sended`  in  1  level; a rising edge marks one byte transmitted.
- `stop`  in  1  level; a rising edge marks an I2C STOP.
- `host_we`  in  1  host write enable.
- `host_addr`  in  `REG_AW`  host register index.
- `host_wdata`  in  8  host write data.
- `host_rdata`  out  8  reg[`host_addr`], combinational read.
- `wr_strobe`  out  1  one-cycle pulse when I2C writes a register.
- `wr_index`  out  `REG_AW`  index written; valid with `wr_strobe`.
- `ptr_err`  out  1  sticky flag for an out-of-range pointer byte; cleared by reset.

## Operation
- Edge detect: `received`, `sended` and `stop` are registered as `last_*`. An event occurs at edge k when the input is sampled high at k and low at k-1.
- FSM states:
  - `ST_PTR`: the next rx event is a pointer byte.
  - `ST_DATA`: rx events are data bytes.
- Reset: state `ST_PTR`, pointer 0, `datasend`=8'h00, `wr_strobe`=0, `wr_index`=0, `ptr_err`=0, `last_*`=0, reg[1..N-1]=8'h00, reg0 reads `CHIP_ID`.
- `ST_PTR`, rx event:
  - If `datareceive` < `REG_COUNT`, pointer = `datareceive`.
  - Otherwise pointer = 0 and `ptr_err` is set.
  - Go to `ST_DATA` and schedule a `datasend` reload.
- `ST_DATA`, rx event:
  - reg[ptr] = `datareceive`, except that writes to index 0 are discarded.
  - `wr_strobe`/`wr_index` pulse in both cases.
  - Pointer increments.
- tx event, in any state: pointer increments and a `datasend` reload is scheduled.
- Pointer wrap: `REG_COUNT`-1 increments to 0.
- stop event: go to `ST_PTR`. The pointer is retained, so a write-pointer followed by a repeated-start read works.
- Simultaneous events (priority order):
  - stop beats rx and tx.
  - rx beats tx; the tx event is dropped.
- I2C write and host write in the same cycle:
  - Same index: the I2C write wins and the host write is lost.
  - Different indices: both are applied.
- Host writes to index 0 are ignored. `host_addr` ≥ `REG_COUNT` reads 8'h00 and ignores writes.
- Reset asserted mid-transaction aborts it; there is no partial write.

## Timing
- Event detected at edge k:
  - Register write, pointer update and `ptr_err` take effect at edge k+1.
  - `wr_strobe` is high for the cycle after k+1.
- `datasend` reload: reg[new pointer] is loaded at edge k+2. The byte engine must not sample `datasend` earlier than 2 cycles after the event edge.
- Minimum spacing of events on any one input: 3 cycles. Inputs are synchronous to `clk`.
- `host_rdata` is combinational from the array. A host write at edge j is visible on `host_rdata` after j.

## Structure
- Package `i2c_slave_pkg`:
  - FSM state encoding (`ST_PTR`, `ST_DATA`).
  - `ZERO8`.
  - Default `SLAVE_ADDRESS`/`CHIP_ID` constants shared with the byte engine.
- Sub-module `i2c_edge_detect`: one instance per strobe input, outputting a one-cycle rise pulse.
- The register array is a flop array inside the block. It is not inferred RAM, because the block needs 2 read ports and 2 write ports.

## Test plan
- Reset release, then pointer 0x00 followed by a read (tx event) → `datasend`=8'hA5, then 0x00 at the next reload.
- Write sequence 0x02, 0x11, 0x22 → reg2=0x11, reg3=0x22; `wr_strobe` pulses with `wr_index`=2, then 3; `host_rdata`@3=0x22.
- `REG_COUNT`=8, pointer 0x07, write 0x55, 0x66 → reg7=0x55, pointer wraps, 0x66 discarded at reg0, `wr_index`=0.
- Pointer 0x09 with `REG_COUNT`=8 → pointer 0, `ptr_err`=1 and stays set after stop.
- Same-cycle I2C write 0x33 and host write 0x44 to reg4 → reg4=0x33. Host write to reg5 in the same cycle as an I2C write to reg4 → both applied.
- Stop mid-write, then byte 0x01 → treated as a pointer; no register changes. Reset asserted with `received` high → all reset values, no write.
